mem_stage: RTL

Memory stage of the pipelined CPU. It consumes the EX/MEM pipeline register outputs and performs data-memory loads and stores over a req/ack handshake, stalling upstream stages while an access is outstanding. It resolves branches and redirects the PC, and it drives the registered MEM/WB values consumed by writeback.

---
 rtl/mem_stage_if.sv | 31 +++
 rtl/mem_stage.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM pipeline stage and the data memory.
// The stage is the master (drives the request); the memory answers with a one-cycle ack.
interface mem_stage_if;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [3:0]  dm_size;
  logic [63:0] dm_rdata;
  logic        dm_ack;

  modport master (
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_wdata,
    output dm_size,
    input  dm_rdata,
    input  dm_ack
  );

  modport slave (
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_wdata,
    input  dm_size,
    output dm_rdata,
    output dm_ack
  );
endinterface

// File: rtl/mem_stage.sv
// CPU memory stage: runs loads/stores over the data-memory handshake, stalls upstream while
// an access is outstanding, resolves branches, and drives the registered MEM/WB values.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_mem,
  input  logic [63:0] alu_result_mem,
  input  logic [63:0] Db_mem,
  input  logic [63:0] new_pc2,
  input  logic [4:0]  Rd_mem,
  input  logic [3:0]  xfer_size_mem,
  input  logic        negative_mem,
  input  logic        zero_mem,
  input  logic        MemtoReg_mem,
  input  logic        MemWrite_mem,
  input  logic        RegWrite_mem,
  input  logic        cbz_mem,
  input  logic        branch_mem,
  input  logic        BRsignal_mem,
  mem_stage_if.master dm,
  output logic        stall,
  output logic        pc_redirect,
  output logic [63:0] redirect_target,
  output logic        flush,
  output logic        wb_valid,
  output logic        wb_RegWrite,
  output logic [4:0]  wb_Rd,
  output logic [63:0] wb_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic        req_reg;
  logic        we_reg;
  logic [63:0] addr_reg;
  logic [63:0] wdata_reg;
  logic [3:0]  size_reg;
  logic [63:0] hold_reg;
  logic        wb_valid_reg;
  logic        wb_regwrite_reg;
  logic [4:0]  wb_rd_reg;
  logic [63:0] wb_data_reg;

  logic memop;
  logic taken;

  assign memop = valid_mem & (MemtoReg_mem | MemWrite_mem);
  assign taken = valid_mem & (branch_mem | (cbz_mem & zero_mem) | (BRsignal_mem & negative_mem));

  // Zero-extend load data to the access size; unknown sizes fall back to the full word.
  function automatic logic [63:0] load_extend(input logic [63:0] data, input logic [3:0] size);
    logic [63:0] result;
    case (size)
      4'd1:    result = {56'd0, data[7:0]};
      4'd2:    result = {48'd0, data[15:0]};
      4'd4:    result = {32'd0, data[31:0]};
      default: result = data;
    endcase
    return result;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      req_reg         <= 1'b0;
      we_reg          <= 1'b0;
      addr_reg        <= 64'd0;
      wdata_reg       <= 64'd0;
      size_reg        <= 4'd0;
      hold_reg        <= 64'd0;
      wb_valid_reg    <= 1'b0;
      wb_regwrite_reg <= 1'b0;
      wb_rd_reg       <= 5'd0;
      wb_data_reg     <= 64'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (memop) begin
            // A load wins when both controls are set.
            req_reg   <= 1'b1;
            we_reg    <= MemWrite_mem & ~MemtoReg_mem;
            addr_reg  <= alu_result_mem;
            wdata_reg <= Db_mem;
            size_reg  <= xfer_size_mem;
            state_reg <= BUSY;
          end else begin
            wb_valid_reg    <= valid_mem;
            wb_regwrite_reg <= RegWrite_mem & valid_mem;
            wb_rd_reg       <= Rd_mem;
            wb_data_reg     <= alu_result_mem;
          end
        end
        BUSY: begin
          if (dm.dm_ack) begin
            hold_reg  <= load_extend(dm.dm_rdata, size_reg);
            req_reg   <= 1'b0;
            state_reg <= DONE;
          end
        end
        DONE: begin
          // The EX/MEM slot is still the memory instruction here, so its Rd/RegWrite apply.
          wb_valid_reg    <= 1'b1;
          wb_regwrite_reg <= RegWrite_mem & valid_mem;
          wb_rd_reg       <= Rd_mem;
          wb_data_reg     <= we_reg ? alu_result_mem : hold_reg;
          state_reg       <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign stall = ~reset & (((state_reg == IDLE) & memop) | (state_reg == BUSY));

  assign pc_redirect     = ~reset & taken;
  assign flush           = ~reset & taken;
  assign redirect_target = new_pc2;

  assign dm.dm_req   = req_reg;
  assign dm.dm_we    = we_reg;
  assign dm.dm_addr  = addr_reg;
  assign dm.dm_wdata = wdata_reg;
  assign dm.dm_size  = size_reg;

  assign wb_valid    = wb_valid_reg;
  assign wb_RegWrite = wb_regwrite_reg;
  assign wb_Rd       = wb_rd_reg;
  assign wb_data     = wb_data_reg;

endmodule
